// File: rtl/cam_cmd_queue.sv
// cam_cmd_queue: in-order command FIFO in front of a CAM. Commands are popped
// one per cycle onto the CAM strobe ports, and the CAM's same-cycle result is
// captured into a single response register with its own valid/ready handshake.
module cam_cmd_queue #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // command side
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_index_i,
  input  logic [WIDTH-1:0]      cmd_data_i,
  // CAM strobes
  output logic                  read_enable_o,
  output logic                  write_enable_o,
  output logic                  search_enable_o,
  output logic [ADDR_WIDTH-1:0] read_index_o,
  output logic [ADDR_WIDTH-1:0] write_index_o,
  output logic [WIDTH-1:0]      write_data_o,
  output logic [WIDTH-1:0]      search_data_o,
  // CAM results (combinational, valid in the strobe cycle)
  input  logic                  read_valid_i,
  input  logic [WIDTH-1:0]      read_value_i,
  input  logic                  search_valid_i,
  input  logic [ADDR_WIDTH-1:0] search_index_i,
  // response side
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [1:0]            rsp_op_o,
  output logic                  rsp_hit_o,
  output logic [WIDTH-1:0]      rsp_data_o,
  output logic [ADDR_WIDTH-1:0] rsp_index_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SEARCH = 2'b10;

  // FIFO storage, one array per command field
  logic [1:0]            fifo_op_q    [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_index_q [DEPTH];
  logic [WIDTH-1:0]      fifo_data_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q, ready_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [1:0]            rsp_op_q, rsp_op_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic [WIDTH-1:0]      rsp_data_q, rsp_data_d;
  logic [ADDR_WIDTH-1:0] rsp_index_q, rsp_index_d;

  logic                  push_s;
  logic                  issue_s;
  logic [1:0]            head_op_s;
  logic [ADDR_WIDTH-1:0] head_index_s;
  logic [WIDTH-1:0]      head_data_s;

  // ready is a register so it is low throughout reset and never depends on
  // same-cycle inputs; a pop in the full cycle does not open a bypass.
  assign push_s       = cmd_valid_i && ready_q;
  assign issue_s      = (count_q != CNT_ZERO) && (!rsp_valid_q || rsp_ready_i);
  assign head_op_s    = fifo_op_q[rd_ptr_q];
  assign head_index_s = fifo_index_q[rd_ptr_q];
  assign head_data_s  = fifo_data_q[rd_ptr_q];

  assign cmd_ready_o  = ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_op_o     = rsp_op_q;
  assign rsp_hit_o    = rsp_hit_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_index_o  = rsp_index_q;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (issue_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, issue_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != CNT_FULL);
  end

  // Decode the head entry onto the CAM ports while a command is issuing.
  always_comb begin
    read_enable_o   = 1'b0;
    write_enable_o  = 1'b0;
    search_enable_o = 1'b0;
    read_index_o    = '0;
    write_index_o   = '0;
    write_data_o    = '0;
    search_data_o   = '0;
    if (issue_s) begin
      case (head_op_s)
        OP_READ: begin
          read_enable_o = 1'b1;
          read_index_o  = head_index_s;
        end
        OP_WRITE: begin
          write_enable_o = 1'b1;
          write_index_o  = head_index_s;
          write_data_o   = head_data_s;
        end
        OP_SEARCH: begin
          search_enable_o = 1'b1;
          search_data_o   = head_data_s;
        end
        default: begin
          read_enable_o = 1'b0;
        end
      endcase
    end else begin
      read_enable_o = 1'b0;
    end
  end

  // Response register: load on issue, clear on consume, otherwise hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_op_d    = rsp_op_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_data_d  = rsp_data_q;
    rsp_index_d = rsp_index_q;
    if (issue_s) begin
      rsp_valid_d = 1'b1;
      rsp_op_d    = head_op_s;
      rsp_hit_d   = 1'b0;
      rsp_data_d  = '0;
      rsp_index_d = head_index_s;
      case (head_op_s)
        OP_READ: begin
          rsp_hit_d  = read_valid_i;
          rsp_data_d = read_value_i;
        end
        OP_WRITE: begin
          rsp_hit_d = 1'b1;
        end
        OP_SEARCH: begin
          rsp_hit_d   = search_valid_i;
          rsp_index_d = search_index_i;
        end
        default: begin
          rsp_hit_d = 1'b0;
        end
      endcase
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
      rsp_op_d    = 2'b00;
      rsp_hit_d   = 1'b0;
      rsp_data_d  = '0;
      rsp_index_d = '0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Control and response state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= 2'b00;
      rsp_hit_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_index_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_q    <= rsp_op_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_data_q  <= rsp_data_d;
      rsp_index_q <= rsp_index_d;
    end
  end

  // FIFO storage write; cleared on reset so stale commands never resurface.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_op_q[i]    <= 2'b00;
        fifo_index_q[i] <= '0;
        fifo_data_q[i]  <= '0;
      end
    end else if (push_s) begin
      fifo_op_q[wr_ptr_q]    <= cmd_op_i;
      fifo_index_q[wr_ptr_q] <= cmd_index_i;
      fifo_data_q[wr_ptr_q]  <= cmd_data_i;
    end else begin
      fifo_op_q[wr_ptr_q] <= fifo_op_q[wr_ptr_q];
    end
  end

endmodule
